// File: rtl/cmplx_mixer_pkg.sv
// rtl/cmplx_mixer_pkg.sv - shared types, product schedule and rounding constant for the complex mixer
package cmplx_mixer_pkg;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_RND, S_OUT} state_t;

    // Partial-product identifiers: a=in_i, b=in_q, c=lo_i, d=lo_q.
    localparam logic [1:0] P_AC = 2'd0;
    localparam logic [1:0] P_BD = 2'd1;
    localparam logic [1:0] P_AD = 2'd2;
    localparam logic [1:0] P_BC = 2'd3;

    function automatic int nph(input int par);
        return 4 / par;
    endfunction

    // Multiplier k in phase ph computes product ph*PAR+k, giving ac,bd,ad,bc order.
    function automatic logic [1:0] sched_idx(input logic [1:0] ph, input int par, input int k);
        int t;
        t = int'(ph) * par + k;
        return 2'(t);
    endfunction

    function automatic longint rnd_const(input int dsz);
        return longint'(1) << (dsz - 2);
    endfunction

endpackage

// File: rtl/cmplx_mixer_sat.sv
// rtl/cmplx_mixer_sat.sv - signed saturator from ISZ to OSZ bits with overflow flag
module cmplx_mixer_sat #(
    parameter int ISZ = 18,
    parameter int OSZ = 16
) (
    input  logic signed [ISZ-1:0] i_data,
    output logic signed [OSZ-1:0] o_data,
    output logic                  o_ovf
);

    logic [ISZ-OSZ:0] w_top;

    // The value fits only when all bits from the output sign bit upward agree.
    assign w_top  = i_data[ISZ-1:OSZ-1];
    assign o_ovf  = !((&w_top) || !(|w_top));
    assign o_data = !o_ovf ? i_data[OSZ-1:0]
                  : (i_data[ISZ-1] ? {1'b1, {(OSZ-1){1'b0}}} : {1'b0, {(OSZ-1){1'b1}}});

endmodule

// File: rtl/cmplx_mixer_seq.sv
// rtl/cmplx_mixer_seq.sv - sequential complex mixer sharing PAR multipliers over NPH phases
module cmplx_mixer_seq
    import cmplx_mixer_pkg::*;
#(
    parameter int DSZ = 16,
    parameter int PAR = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic signed [DSZ-1:0] i_in_i,
    input  logic signed [DSZ-1:0] i_in_q,
    input  logic signed [DSZ-1:0] i_lo_i,
    input  logic signed [DSZ-1:0] i_lo_q,
    input  logic                  i_conj,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic signed [DSZ-1:0] o_out_i,
    output logic signed [DSZ-1:0] o_out_q,
    output logic                  o_sat_flag,
    input  logic                  i_sat_clr
);

    localparam int NPH = nph(PAR);
    localparam int PW  = 2 * DSZ;
    localparam int AW  = 2 * DSZ + 1;
    localparam logic signed [AW-1:0] RND_K = AW'(rnd_const(DSZ));

    state_t                r_state;
    logic [1:0]            r_phase;
    logic signed [DSZ-1:0] r_a, r_b, r_c, r_d;
    logic                  r_conj;
    logic signed [AW-1:0]  r_acc_i, r_acc_q;

    logic signed [AW-1:0]  w_term [PAR];
    logic                  w_to_i [PAR];
    logic signed [AW-1:0]  w_sum_i, w_sum_q;
    logic signed [AW-1:0]  w_rsum_i, w_rsum_q;
    logic signed [DSZ-1:0] w_sat_i, w_sat_q;
    logic                  w_ovf_i, w_ovf_q;
    logic                  w_unused_lsb;

    for (genvar k = 0; k < PAR; k++) begin : g_mul
        logic [1:0]            w_idx;
        logic signed [DSZ-1:0] w_x, w_y;
        logic signed [PW-1:0]  w_p;
        logic                  w_neg;

        assign w_idx     = sched_idx(r_phase, PAR, k);
        assign w_x       = (w_idx == P_AC || w_idx == P_AD) ? r_a : r_b;
        assign w_y       = (w_idx == P_AC || w_idx == P_BC) ? r_c : r_d;
        assign w_p       = w_x * w_y;
        assign w_to_i[k] = (w_idx == P_AC || w_idx == P_BD);
        // Conjugation only flips which cross term is subtracted.
        assign w_neg     = (w_idx == P_BD && !r_conj) || (w_idx == P_AD && r_conj);
        assign w_term[k] = w_neg ? -AW'(w_p) : AW'(w_p);
    end

    always_comb begin
        w_sum_i = '0;
        w_sum_q = '0;
        for (int k = 0; k < PAR; k++) begin
            if (w_to_i[k]) w_sum_i = w_sum_i + w_term[k];
            else           w_sum_q = w_sum_q + w_term[k];
        end
    end

    assign w_rsum_i     = r_acc_i + RND_K;
    assign w_rsum_q     = r_acc_q + RND_K;
    assign w_unused_lsb = ^{w_rsum_i[DSZ-2:0], w_rsum_q[DSZ-2:0]};

    cmplx_mixer_sat #(.ISZ(DSZ + 2), .OSZ(DSZ)) u_sat_i (
        .i_data (w_rsum_i[AW-1:DSZ-1]),
        .o_data (w_sat_i),
        .o_ovf  (w_ovf_i)
    );

    cmplx_mixer_sat #(.ISZ(DSZ + 2), .OSZ(DSZ)) u_sat_q (
        .i_data (w_rsum_q[AW-1:DSZ-1]),
        .o_data (w_sat_q),
        .o_ovf  (w_ovf_q)
    );

    assign o_in_ready = i_rst_n && ((r_state == S_IDLE) || (r_state == S_OUT && i_out_ready));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_conj      <= 1'b0;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            o_out_valid <= 1'b0;
            o_out_i     <= '0;
            o_out_q     <= '0;
            o_sat_flag  <= 1'b0;
        end else begin
            if (i_sat_clr)                                      o_sat_flag <= 1'b0;
            else if (r_state == S_RND && (w_ovf_i || w_ovf_q)) o_sat_flag <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_state <= S_MUL;
                        r_phase <= '0;
                        r_a     <= i_in_i;
                        r_b     <= i_in_q;
                        r_c     <= i_lo_i;
                        r_d     <= i_lo_q;
                        r_conj  <= i_conj;
                        r_acc_i <= '0;
                        r_acc_q <= '0;
                    end
                end
                S_MUL: begin
                    r_acc_i <= r_acc_i + w_sum_i;
                    r_acc_q <= r_acc_q + w_sum_q;
                    if (r_phase == 2'(NPH - 1)) r_state <= S_RND;
                    else                        r_phase <= r_phase + 2'd1;
                end
                S_RND: begin
                    o_out_i     <= w_sat_i;
                    o_out_q     <= w_sat_q;
                    o_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        if (i_in_valid) begin
                            r_state <= S_MUL;
                            r_phase <= '0;
                            r_a     <= i_in_i;
                            r_b     <= i_in_q;
                            r_c     <= i_lo_i;
                            r_d     <= i_lo_q;
                            r_conj  <= i_conj;
                            r_acc_i <= '0;
                            r_acc_q <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmplx_mixer_seq.sv
// tb/tb_cmplx_mixer_seq.sv - self-checking bench for cmplx_mixer_seq at PAR=1,2,4
module tb_cmplx_mixer_seq;

    typedef struct {
        int     u;
        longint i;
        longint q;
        bit     sat;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                tb_in_valid [3];
    logic                tb_in_ready [3];
    logic                tb_conj     [3];
    logic                tb_out_valid[3];
    logic                tb_out_ready[3];
    logic                tb_sat_flag [3];
    logic                tb_sat_clr  [3];
    logic signed [15:0]  tb_in_i [3];
    logic signed [15:0]  tb_in_q [3];
    logic signed [15:0]  tb_lo_i [3];
    logic signed [15:0]  tb_lo_q [3];
    logic signed [15:0]  tb_out_i[3];
    logic signed [15:0]  tb_out_q[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cmplx_mixer_seq #(.DSZ(16), .PAR(1 << g)) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_in_valid  (tb_in_valid[g]),
            .o_in_ready  (tb_in_ready[g]),
            .i_in_i      (tb_in_i[g]),
            .i_in_q      (tb_in_q[g]),
            .i_lo_i      (tb_lo_i[g]),
            .i_lo_q      (tb_lo_q[g]),
            .i_conj      (tb_conj[g]),
            .o_out_valid (tb_out_valid[g]),
            .i_out_ready (tb_out_ready[g]),
            .o_out_i     (tb_out_i[g]),
            .o_out_q     (tb_out_q[g]),
            .o_sat_flag  (tb_sat_flag[g]),
            .i_sat_clr   (tb_sat_clr[g])
        );
    end

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   rnd_stall = 1'b0;
    res_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic res_t model(input int u, input longint a, input longint b,
                                   input longint c, input longint d, input bit cj);
        res_t   r;
        longint vi, vq;
        vi = cj ? (a * c + b * d) : (a * c - b * d);
        vq = cj ? (b * c - a * d) : (a * d + b * c);
        vi = (vi + 16384) >>> 15;
        vq = (vq + 16384) >>> 15;
        r.u   = u;
        r.sat = (vi > 32767) || (vi < -32768) || (vq > 32767) || (vq < -32768);
        r.i   = (vi > 32767) ? 32767 : ((vi < -32768) ? -32768 : vi);
        r.q   = (vq > 32767) ? 32767 : ((vq < -32768) ? -32768 : vq);
        return r;
    endfunction

    always begin
        @(negedge clk);
        out_ready_drive();
    end

    task automatic out_ready_drive();
        for (int u = 0; u < 3; u++)
            tb_out_ready[u] = rnd_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    logic               pv[3];
    logic               pr[3];
    logic signed [15:0] pi[3];
    logic signed [15:0] pq[3];

    always begin
        @(negedge clk);
        #2;
        for (int u = 0; u < 3; u++) begin
            if (!rst_n) begin
                pv[u] = 1'b0;
            end else begin
                if (pv[u] && !pr[u]) begin
                    chk("stall_hold_valid", tb_out_valid[u], 1);
                    chk("stall_hold_i", tb_out_i[u], pi[u]);
                    chk("stall_hold_q", tb_out_q[u], pq[u]);
                end
                if (tb_out_valid[u]) begin
                    if (!tb_out_ready[u]) chk("stall_in_ready", tb_in_ready[u], 0);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_out: unit %0d gave (%0d,%0d), none expected",
                                 u, tb_out_i[u], tb_out_q[u]);
                    end else begin
                        chk("out_unit", u, exp_q[0].u);
                        chk("out_i", tb_out_i[u], exp_q[0].i);
                        chk("out_q", tb_out_q[u], exp_q[0].q);
                        if (tb_out_ready[u]) void'(exp_q.pop_front());
                    end
                end
                pv[u] = tb_out_valid[u];
                pr[u] = tb_out_ready[u];
                pi[u] = tb_out_i[u];
                pq[u] = tb_out_q[u];
            end
        end
    end

    task automatic send(input int u, input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [15:0] c, input logic signed [15:0] d,
                        input bit cj, input bit keep);
        int w;
        @(negedge clk);
        tb_in_valid[u] = 1'b1;
        tb_in_i[u] = a;
        tb_in_q[u] = b;
        tb_lo_i[u] = c;
        tb_lo_q[u] = d;
        tb_conj[u] = cj;
        #1;
        w = 0;
        while (!tb_in_ready[u] && w < 60) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!tb_in_ready[u]) begin
            chk("in_ready_timeout", tb_in_ready[u], 1);
            tb_in_valid[u] = 1'b0;
            return;
        end
        exp_q.push_back(model(u, a, b, c, d, cj));
        @(posedge clk);
        #1;
        if (!keep) begin
            tb_in_valid[u] = 1'b0;
            tb_in_i[u] = 16'($urandom());
            tb_lo_q[u] = 16'($urandom());
            tb_conj[u] = ~cj;
        end
    endtask

    task automatic dir(input int u, input logic signed [15:0] a, input logic signed [15:0] b,
                       input logic signed [15:0] c, input logic signed [15:0] d,
                       input bit cj, input longint ei, input longint eq);
        int lat;
        send(u, a, b, c, d, cj, 1'b0);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!tb_out_valid[u] && lat < 20);
        chk("latency", lat, (4 >> u) + 1);
        chk("lit_i", tb_out_i[u], ei);
        chk("lit_q", tb_out_q[u], eq);
    endtask

    task automatic drain();
        int w;
        w = 0;
        @(negedge clk);
        for (int u = 0; u < 3; u++) tb_in_valid[u] = 1'b0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    function automatic logic signed [15:0] rv();
        case ($urandom_range(0, 7))
            0:       return -16'sd32768;
            1:       return 16'sd32767;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        res_t m;
        int   t0;
        for (int u = 0; u < 3; u++) begin
            tb_in_valid[u] = 1'b0;
            tb_in_i[u] = '0;
            tb_in_q[u] = '0;
            tb_lo_i[u] = '0;
            tb_lo_q[u] = '0;
            tb_conj[u] = 1'b0;
            tb_sat_clr[u] = 1'b0;
        end

        m = model(0, 16384, 0, 32767, 0, 1'b0);
        chk("model_pin_a", m.i, 16384);
        m = model(0, 0, 16384, 0, 16384, 1'b0);
        chk("model_pin_b", m.i, -8192);
        m = model(0, -32768, -32768, -32768, -32768, 1'b0);
        chk("model_pin_c", m.q, 32767);
        chk("model_pin_sat", m.sat, 1);

        repeat (2) @(negedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk("rst_out_valid", tb_out_valid[u], 0);
            chk("rst_in_ready", tb_in_ready[u], 0);
            chk("rst_sat_flag", tb_sat_flag[u], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", tb_in_ready[0], 1);

        for (int u = 0; u < 3; u++) begin
            dir(u, 16384, 0, 32767, 0, 1'b0, 16384, 0);
            chk("no_sat", tb_sat_flag[u], 0);
            dir(u, 0, 16384, 0, 16384, 1'b0, -8192, 0);
            dir(u, 0, 16384, 0, 16384, 1'b1, 8192, 0);
        end

        dir(0, -32768, -32768, -32768, -32768, 1'b0, 0, 32767);
        chk("sat_set", tb_sat_flag[0], 1);
        tb_sat_clr[0] = 1'b1;
        dir(0, -32768, -32768, -32768, -32768, 1'b0, 0, 32767);
        chk("sat_clr_wins", tb_sat_flag[0], 0);
        @(negedge clk);
        tb_sat_clr[0] = 1'b0;
        dir(0, -32768, -32768, -32768, -32768, 1'b0, 0, 32767);
        chk("sat_set_again", tb_sat_flag[0], 1);

        send(0, 1000, 2000, 3000, -4000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", tb_out_valid[0], 0);
        chk("midrst_out_q", tb_out_q[0], 0);
        chk("midrst_sat_flag", tb_sat_flag[0], 0);
        chk("midrst_in_ready", tb_in_ready[0], 0);
        exp_q.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("held_rst_in_ready", tb_in_ready[0], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", tb_in_ready[0], 1);
        dir(0, 1000, 2000, 3000, -4000, 1'b0, 336, 61);
        drain();

        t0 = 0;
        for (int n = 0; n < 6; n++) begin
            send(0, 16'(n * 1000), 16'(-n * 500), 20000, 7000, n[0], 1'b1);
            if (n > 0) chk("stream_period", cyc - t0, 6);
            t0 = cyc;
        end
        drain();

        for (int u = 0; u < 3; u++) begin
            rnd_stall = 1'b1;
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    tb_in_valid[u] = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                send(u, rv(), rv(), rv(), rv(), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            end
            drain();
            rnd_stall = 1'b0;
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
